// File: rtl/victim_way_select.sv
// victim_way_select
//    Cache replacement front end. One allocation request from the miss FSM
//    becomes a registered one-hot write-enable vector for exactly one way of
//    the addressed set. This is the counterpart of the N->1 OR reduction used
//    for hit detection.
//
//    The victim is chosen as follows:
//    - If any way is invalid, the lowest-index invalid way is chosen.
//    - Otherwise a round-robin pointer is used.
//
// Parameters
//    WAYS        number of ways, 2..16; need not be a power of two
//    IDX_W       width of way_index; 2**IDX_W >= WAYS
//
// Ports
//    clk         rising-edge clock
//    reset       asynchronous, active-high
//    req         allocation request; level, held until ack is seen
//    valid_mask  [0:WAYS-1] valid bits of the set; bit 0 = way 0
//    ack         grant valid
//    way_onehot  [0:WAYS-1] selected way; one-hot while ack=1, else all 0
//    way_index   binary index of the selected way; 0 while ack=0
//
// Optional feature, enabled by defining VICTIM_LOCK_EN
//    lock_mask   [0:WAYS-1] in; 1 = way pinned, never selectable
//    no_victim   out; high with ack when every way is locked
//
// State table
//    state | meaning
//    IDLE  | waiting for req; outputs are all zero
//    GRANT | outputs hold the registered victim until req drops
module victim_way_select #(
   parameter int WAYS  = 4,
   parameter int IDX_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [0:WAYS-1]   valid_mask,
`ifdef VICTIM_LOCK_EN
   input  logic [0:WAYS-1]   lock_mask,
   output logic              no_victim,
`endif
   output logic              ack,
   output logic [0:WAYS-1]   way_onehot,
   output logic [IDX_W-1:0]  way_index
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   ptr_next;
   logic               ack_next;
   logic [0:WAYS-1]    onehot_next;
   logic [IDX_W-1:0]   index_next;
   logic               nv_next;
   logic               nv_q;

   // Victim selection results, valid whenever state == IDLE.
   logic [IDX_W-1:0]   victim;
   logic [IDX_W-1:0]   ptr_adv;
   logic               none_free;

   // Advance a way index by one, wrapping at WAYS rather than 2**IDX_W.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] r;
      if (p == IDX_W'(WAYS - 1)) r = '0;
      else                       r = p + 1'b1;
      return r;
   endfunction

`ifdef VICTIM_LOCK_EN
   logic               found_inv;
   logic               found_rr;
   logic [IDX_W-1:0]   rr_way;
   logic [IDX_W:0]     rr_sum;
   logic [IDX_W-1:0]   rr_pos;

   always_comb begin
      victim    = '0;
      ptr_adv   = ptr;
      none_free = 1'b0;
      found_inv = 1'b0;
      found_rr  = 1'b0;
      rr_way    = '0;
      rr_sum    = '0;
      rr_pos    = '0;

      // Descending scan: the last hit is the lowest-index invalid candidate.
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!lock_mask[i] && !valid_mask[i]) begin
            victim    = IDX_W'(i);
            found_inv = 1'b1;
         end
      end

      // Cyclic scan starting at ptr. Descending offsets so the smallest
      // offset (first unlocked way at or after ptr) wins. ptr < WAYS and
      // k < WAYS, so a single conditional subtract performs the modulo.
      for (int k = WAYS - 1; k >= 0; k--) begin
         rr_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (rr_sum >= (IDX_W + 1)'(WAYS))
            rr_sum = rr_sum - (IDX_W + 1)'(WAYS);
         rr_pos = rr_sum[IDX_W-1:0];
         if (!lock_mask[rr_pos]) begin
            rr_way   = rr_pos;
            found_rr = 1'b1;
         end
      end

      if (found_inv) begin
         ptr_adv = ptr;
      end else if (found_rr) begin
         victim  = rr_way;
         ptr_adv = wrap_inc(rr_way);
      end else begin
         victim    = '0;
         none_free = 1'b1;
      end
   end

   assign no_victim = nv_q;
`else
   logic found_inv;

   always_comb begin
      victim    = '0;
      ptr_adv   = ptr;
      none_free = 1'b0;
      found_inv = 1'b0;

      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid_mask[i]) begin
            victim    = IDX_W'(i);
            found_inv = 1'b1;
         end
      end

      if (!found_inv) begin
         victim  = ptr;
         ptr_adv = wrap_inc(ptr);
      end
   end
`endif

   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      ack_next    = ack;
      onehot_next = way_onehot;
      index_next  = way_index;
      nv_next     = nv_q;

      unique case (state)
         IDLE: begin
            if (req) begin
               ack_next    = 1'b1;
               onehot_next = '0;
               if (!none_free) onehot_next[victim] = 1'b1;
               index_next  = victim;
               nv_next     = none_free;
               ptr_next    = ptr_adv;
               state_next  = GRANT;
            end
         end
         GRANT: begin
            // valid_mask is deliberately ignored here; outputs hold until
            // req drops.
            if (!req) begin
               ack_next    = 1'b0;
               onehot_next = '0;
               index_next  = '0;
               nv_next     = 1'b0;
               state_next  = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         ack        <= 1'b0;
         way_onehot <= '0;
         way_index  <= '0;
         nv_q       <= 1'b0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         ack        <= ack_next;
         way_onehot <= onehot_next;
         way_index  <= index_next;
         nv_q       <= nv_next;
      end
   end

endmodule
